// File: rtl/uart_boot_mem.sv
// uart_boot_mem: word RAM serving the core bus, preloaded over a UART (8N1) boot link.
// After reset a word count plus that many little-endian words arrive on rxd and are
// written from word 0; core_run then rises and the core owns the RAM.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing 8-bit sum byte.
module uart_boot_mem #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int ADDR_W           = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic [31:0]       adr,
    input  logic [31:0]       writedata,
    input  logic              memwrite,
    output logic [31:0]       readdata,
    output logic              core_run,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W:0]   WL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [31:0]       DEPTH_W = 32'(DEPTH);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] LD_CNT  = 3'd0;
    localparam logic [2:0] LD_DATA = 3'd1;
    localparam logic [2:0] LD_RUN  = 3'd3;
    localparam logic [2:0] LD_ERR  = 3'd4;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] LD_SUM  = 3'd2;
    localparam logic [2:0] LD_DONE = LD_SUM;
`else
    localparam logic [2:0] LD_DONE = LD_RUN;
`endif

    logic              rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [1:0]        rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_valid_s, frame_err_s;

    logic [2:0]        ld_state_q, ld_state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic              ld_loading_s;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              core_run_q, load_err_q;
    logic [31:0]       readdata_q;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [31:0]       mem_wdata_s;
    logic [31:0]       mem [0:DEPTH-1];
    logic              unused_adr_s;

    assign unused_adr_s = ^{adr[31:ADDR_W+2], adr[1:0]};

    // UART receiver: detect start edge, sample mid-bit, validate the stop bit
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = HALF_M1;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rxd_sync_q) begin
                    rx_state_d = RX_IDLE;     // start bit vanished: a glitch
                end else begin
                    rx_state_d = RX_DATA;
                    cnt_d      = FULL_M1;
                    bit_idx_d  = 3'd0;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    rx_state_d = RX_IDLE;
                    if (rxd_sync_q) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

`ifdef BOOT_CHECKSUM_EN
    assign ld_loading_s = (ld_state_q == LD_CNT) || (ld_state_q == LD_DATA) || (ld_state_q == LD_SUM);
`else
    assign ld_loading_s = (ld_state_q == LD_CNT) || (ld_state_q == LD_DATA);
`endif

    // Loader sequencing plus the single RAM write port shared with the core in RUN
    always_comb begin
        ld_state_d     = ld_state_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        count_d        = count_q;
        words_loaded_d = words_loaded_q;
        mem_we_s       = 1'b0;
        mem_waddr_s    = adr[ADDR_W+1:2];
        mem_wdata_s    = writedata;
`ifdef BOOT_CHECKSUM_EN
        sum_d          = sum_q;
`endif
        if (frame_err_s && ld_loading_s) begin
            ld_state_d = LD_ERR;
        end else if (byte_valid_s && ld_loading_s) begin
            word_d     = {shift_q, word_q[31:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            sum_d      = sum_q + shift_q;
`endif
            case (ld_state_q)
                LD_CNT: begin
                    if (byte_cnt_q == 2'd3) begin
                        count_d = word_d[ADDR_W:0];
                        if (word_d > DEPTH_W) begin
                            ld_state_d = LD_ERR;
                        end else if (word_d == 32'd0) begin
                            ld_state_d = LD_DONE;
                        end else begin
                            ld_state_d = LD_DATA;
                        end
                    end else begin
                        ld_state_d = LD_CNT;
                    end
                end
                LD_DATA: begin
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_s       = 1'b1;
                        mem_waddr_s    = words_loaded_q[ADDR_W-1:0];
                        mem_wdata_s    = word_d;
                        words_loaded_d = words_loaded_q + WL_ONE;
                        if (words_loaded_d == count_q) begin
                            ld_state_d = LD_DONE;
                        end else begin
                            ld_state_d = LD_DATA;
                        end
                    end else begin
                        ld_state_d = LD_DATA;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                LD_SUM: begin
                    if (shift_q == sum_q) begin
                        ld_state_d = LD_RUN;
                    end else begin
                        ld_state_d = LD_ERR;
                    end
                end
`endif
                default: begin
                    ld_state_d = LD_ERR;
                end
            endcase
        end else if ((ld_state_q == LD_RUN) && memwrite) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // State, synchronizer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q     <= 1'b1;
            rxd_sync_q     <= 1'b1;
            rxd_prev_q     <= 1'b1;
            rx_state_q     <= RX_IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= 3'd0;
            shift_q        <= 8'd0;
            ld_state_q     <= LD_CNT;
            byte_cnt_q     <= 2'd0;
            word_q         <= 32'd0;
            count_q        <= '0;
            words_loaded_q <= '0;
            core_run_q     <= 1'b0;
            load_err_q     <= 1'b0;
            readdata_q     <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
            sum_q          <= 8'd0;
`endif
        end else begin
            rxd_meta_q     <= rxd;
            rxd_sync_q     <= rxd_meta_q;
            rxd_prev_q     <= rxd_sync_q;
            rx_state_q     <= rx_state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            ld_state_q     <= ld_state_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            count_q        <= count_d;
            words_loaded_q <= words_loaded_d;
            core_run_q     <= (ld_state_d == LD_RUN);
            load_err_q     <= (ld_state_d == LD_ERR);
            readdata_q     <= mem[adr[ADDR_W+1:2]];
`ifdef BOOT_CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    // RAM array: contents survive reset; read in the block above is read-first
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign readdata     = readdata_q;
    assign core_run     = core_run_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_uart_boot_mem.sv
// Testbench for uart_boot_mem: random loads and core accesses against a byte-level
// reference model; expectations are queued at issue time and checked by a monitor.
module tb_uart_boot_mem;
    localparam int HALF   = 4;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int BIT_NS = 80;          // 2*HALF clocks of 10 ns

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [31:0] adr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic        memwrite = 1'b0;
    logic [31:0] readdata;
    logic        core_run;
    logic        load_err;
    logic [AW:0] words_loaded;

    uart_boot_mem #(.CLK_PER_HALF_BIT(HALF), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .adr(adr), .writedata(writedata),
        .memwrite(memwrite), .readdata(readdata), .core_run(core_run),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Scoreboard: kind 0 = readdata, 1 = status {run,err,words}, 2 = everything at reset value
    int          kind_q[$];
    logic [31:0] data_q[$];
    logic [6:0]  st_q[$];
    string       name_q[$];
    logic        issue = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    // Reference model
    logic [31:0] mdl_mem [DEPTH];
    bit          mdl_run, mdl_err;
    int          mdl_words;

    // Monitor: one queued expectation per clock while issue is high
    always @(posedge clk) begin
        if (issue) begin
            int          k;
            logic [31:0] ed;
            logic [6:0]  es;
            logic [6:0]  as;
            string       nm;
            #1;
            n_checks++;
            as = {core_run, load_err, words_loaded};
            if (kind_q.size() == 0) begin
                $display("FAIL monitor: output presented with empty expectation queue");
            end else begin
                k  = kind_q.pop_front();
                ed = data_q.pop_front();
                es = st_q.pop_front();
                nm = name_q.pop_front();
                if (k == 0) begin
                    if (readdata === ed) n_pass++;
                    else $display("FAIL %s: readdata got %h expected %h", nm, readdata, ed);
                end else if (k == 1) begin
                    if (as === es) n_pass++;
                    else $display("FAIL %s: {run,err,words} got %b expected %b", nm, as, es);
                end else begin
                    if (readdata === 32'd0 && as === 7'd0) n_pass++;
                    else $display("FAIL %s: reset got rd=%h st=%b expected rd=0 st=0", nm, readdata, as);
                end
            end
        end
    end

    task automatic push_exp(input int k, input logic [31:0] d, input logic [6:0] s, input string nm);
        kind_q.push_back(k);
        data_q.push_back(d);
        st_q.push_back(s);
        name_q.push_back(nm);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(DEPTH));
    endfunction

    task automatic expect_status(input string nm);
        @(negedge clk);
        push_exp(1, 32'd0, {mdl_run, mdl_err, 5'(mdl_words)}, nm);
        issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
    endtask

    task automatic expect_read(input logic [31:0] a, input string nm);
        @(negedge clk);
        adr = a;
        push_exp(0, mdl_mem[widx(a)], 7'd0, nm);
        issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
    endtask

    // Write one clock; same-cycle read must show old data, next clock the new data
    task automatic write_read(input logic [31:0] a, input logic [31:0] d, input string nm);
        @(negedge clk);
        adr = a; writedata = d; memwrite = 1'b1;
        push_exp(0, mdl_mem[widx(a)], 7'd0, {nm, "_old"});
        issue = 1'b1;
        if (mdl_run) mdl_mem[widx(a)] = d;
        @(negedge clk);
        memwrite = 1'b0;
        push_exp(0, mdl_mem[widx(a)], 7'd0, {nm, "_new"});
        @(negedge clk);
        issue = 1'b0;
    endtask

    // Write attempted without checking (outside RUN it must be ignored)
    task automatic blind_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        adr = a; writedata = d; memwrite = 1'b1;
        if (mdl_run) mdl_mem[widx(a)] = d;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1; rxd = 1'b1; memwrite = 1'b0;
        mdl_run = 1'b0; mdl_err = 1'b0; mdl_words = 0;
        @(negedge clk);
        push_exp(2, 32'd0, 7'd0, nm);
        issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        @(negedge clk);
        rxd = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #BIT_NS;
        end
        rxd = stop;
        #BIT_NS;
        rxd = 1'b1;
        #BIT_NS;
    endtask

    // Model of a complete byte stream as seen by the loader
    task automatic ref_load(input logic [7:0] b[$]);
        int unsigned n;
        logic [7:0]  s;
        n = {b[3], b[2], b[1], b[0]};
        mdl_words = 0;
        if (n > DEPTH) begin
            mdl_err = 1'b1;
            return;
        end
        for (int w = 0; w < int'(n); w++) begin
            if (4 * w + 7 < b.size()) begin
                mdl_mem[w] = {b[4*w+7], b[4*w+6], b[4*w+5], b[4*w+4]};
                mdl_words++;
            end
        end
        if (mdl_words == int'(n)) begin
`ifdef BOOT_CHECKSUM_EN
            if (b.size() > 4 + 4 * int'(n)) begin
                s = 8'd0;
                for (int i = 0; i < 4 + 4 * int'(n); i++) s = s + b[i];
                if (s == b[4 + 4 * int'(n)]) mdl_run = 1'b1;
                else mdl_err = 1'b1;
            end
`else
            s = 8'd0;
            mdl_run = 1'b1;
`endif
        end
    endtask

    task automatic send_stream(input logic [7:0] b[$]);
        foreach (b[i]) send_byte(b[i], 1'b1);
        ref_load(b);
    endtask

    task automatic run_load(input logic [31:0] w[$], input bit bad_sum);
        logic [7:0]  b[$];
        logic [31:0] n;
        logic [7:0]  s;
        n = 32'(w.size());
        for (int i = 0; i < 4; i++) b.push_back(n[8*i +: 8]);
        foreach (w[j]) for (int i = 0; i < 4; i++) b.push_back(w[j][8*i +: 8]);
`ifdef BOOT_CHECKSUM_EN
        s = 8'd0;
        foreach (b[i]) s = s + b[i];
        b.push_back(bad_sum ? s + 8'd1 : s);
`else
        s = {7'd0, bad_sum};
`endif
        send_stream(b);
    endtask

    logic [31:0] wq[$];
    logic [7:0]  bq[$];

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        do_reset("reset_values");
        expect_status("idle_after_reset");

        // Pre-RUN write ignored, then the reference boot image
        blind_write(32'h0, 32'hFFFF_FFFF);
        wq = {};
        wq.push_back(32'hDEAD_BEEF);
        wq.push_back(32'h0000_0013);
        run_load(wq, 1'b0);
        expect_status("load2_status");
        expect_read(32'h0, "load2_word0");
        expect_read(32'h4, "load2_word1");

        // Full-depth load (N == DEPTH is legal)
        do_reset("reset_before_full");
        wq = {};
        for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
        run_load(wq, 1'b0);
        expect_status("full_load_status");
        for (int i = 0; i < DEPTH; i++) expect_read(32'(4 * i), "full_load_read");

        // Core accesses in RUN: write-then-read, read-first, address wrap
        write_read(32'h8, 32'h1234_5678, "run_wr8");
        expect_read(32'h8, "run_rd8");
        expect_read(32'hFFFF_FF48, "wrap_rd");
        for (int i = 0; i < 10; i++) write_read($urandom, $urandom, "rand_wr");
        write_read(32'h1C, 32'hCAFE_0007, "run_wr7");

        // Outside RUN the core write is dropped; RAM keeps old contents over reset
        do_reset("reset_before_prerun");
        blind_write(32'h1C, 32'hFFFF_FFFF);
        wq = {};
        wq.push_back($urandom);
        wq.push_back($urandom);
        run_load(wq, 1'b0);
        expect_status("load_rand2_status");
        expect_read(32'h1C, "prerun_write_ignored");
        expect_read(32'h0, "load_rand2_w0");
        expect_read(32'h4, "load_rand2_w1");

        // Count too large: error, later bytes ignored
        do_reset("reset_before_cnt17");
        bq = {8'd17, 8'd0, 8'd0, 8'd0, 8'h44, 8'h33, 8'h22, 8'h11};
        send_stream(bq);
        expect_status("cnt17_error");

        // Framing error
        do_reset("reset_before_frame");
        send_byte(8'h5A, 1'b0);
        mdl_err = 1'b1;
        expect_status("framing_error");

        // Short low glitch on idle line produces no byte
        do_reset("reset_before_glitch");
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        expect_status("glitch_idle");
        wq = {};
        wq.push_back($urandom);
        run_load(wq, 1'b0);
        expect_status("after_glitch_status");
        expect_read(32'h0, "after_glitch_w0");

        // Reset in the middle of a load, then a clean reload
        do_reset("reset_before_abort");
        bq = {8'd3, 8'd0, 8'd0, 8'd0, 8'hA5};
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        do_reset("reset_mid_load");
        wq = {};
        for (int i = 0; i < 3; i++) wq.push_back($urandom);
        run_load(wq, 1'b0);
        expect_status("reload_status");
        for (int i = 0; i < 3; i++) expect_read(32'(4 * i), "reload_read");
`ifdef BOOT_CHECKSUM_EN
        do_reset("reset_before_badsum");
        wq = {};
        wq.push_back($urandom);
        run_load(wq, 1'b1);
        expect_status("bad_checksum");
`endif

        repeat (4) @(negedge clk);
        n_checks++;
        if (kind_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: %0d expectations left, required 0", kind_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
